// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle control unit: sequencer states,
// opcode classes and instruction-register field positions.
package cpu_defs;

  localparam int OPW = 5;
  localparam int IRW = 32;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam logic [OPW-1:0] ALU_FIRST = 5'b00011;
  localparam logic [OPW-1:0] ALU_LAST  = 5'b01100;
  localparam logic [OPW-1:0] OP_MUL    = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV    = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG    = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT    = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP    = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT   = 5'b11011;

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational classification of the IR opcode field into instruction classes.
module opcode_class_decode
  import cpu_defs::*;
(
  input  logic [OPW-1:0] op,
  output logic           is_alu,
  output logic           is_muldiv,
  output logic           is_unary,
  output logic           is_nop,
  output logic           is_halt,
  output logic           is_illegal
);

  always_comb begin
    is_alu     = (op >= ALU_FIRST) && (op <= ALU_LAST);
    is_muldiv  = (op == OP_MUL) || (op == OP_DIV);
    is_unary   = (op == OP_NEG) || (op == OP_NOT);
    is_nop     = (op == OP_NOP);
    is_halt    = (op == OP_HALT);
    is_illegal = !(is_alu || is_muldiv || is_unary || is_nop || is_halt);
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/execute sequencer producing every Datapath strobe as a
// Moore function of the state register and the IR opcode.
module control_sequencer
  import cpu_defs::*;
(
  input  logic           Clock,
  input  logic           Clear,
  input  logic           Stop,
  input  logic [IRW-1:0] IR,
  output logic           Run,
  output logic           PCout,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           MDRout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           LOin,
  output logic           HIin,
  output logic           IncPC,
  output logic           Read,
  output logic [OPW-1:0] Operation,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           Illegal
);

  state_t         state, state_next, fetch_target;
  logic           stop_flag;
  logic [OPW-1:0] opcode;
  logic           is_alu, is_muldiv, is_unary, is_nop, is_halt, is_illegal;
  logic           unused_ir_fields;

  assign opcode           = IR[OP_HI:OP_LO];
  assign unused_ir_fields = ^IR[OP_LO-1:0];

  opcode_class_decode u_decode (
    .op         (opcode),
    .is_alu     (is_alu),
    .is_muldiv  (is_muldiv),
    .is_unary   (is_unary),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // The stop request stays pending until the next instruction boundary.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state     <= RESET;
      stop_flag <= 1'b0;
    end else begin
      state     <= state_next;
      stop_flag <= stop_flag | Stop;
    end
  end

  always_comb begin
    state_next   = state;
    fetch_target = stop_flag ? HALT : T0;
    Run = 1'b0; PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; LOin = 1'b0; HIin = 1'b0; IncPC = 1'b0; Read = 1'b0;
    Operation = '0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; Illegal = 1'b0;
    case (state)
      RESET: state_next = T0;
      T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_next = T1;
      end
      T1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_next = T2;
      end
      T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_next = T3;
      end
      T3: begin
        Run = 1'b1;
        if (is_alu || is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          state_next = T4;
        end else if (is_unary) begin
          state_next = T4;
        end else if (is_halt) begin
          state_next = HALT;
        end else begin
          Illegal    = is_illegal;
          state_next = fetch_target;
        end
      end
      // Unary ops take their single operand from Rb; two-operand ops read Rc here.
      T4: begin
        Run = 1'b1;
        if (is_alu || is_muldiv || is_unary) begin
          Operation = opcode; Zin = 1'b1; Rout = 1'b1;
          Grc = !is_unary; Grb = is_unary;
          state_next = T5;
        end else begin
          state_next = fetch_target;
        end
      end
      T5: begin
        Run = 1'b1;
        if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
          state_next = T6;
        end else if (is_alu || is_unary) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          state_next = fetch_target;
        end else begin
          state_next = fetch_target;
        end
      end
      T6: begin
        Run = 1'b1; Zhighout = 1'b1; HIin = 1'b1;
        state_next = fetch_target;
      end
      HALT:    state_next = HALT;
      default: state_next = RESET;
    endcase
  end

endmodule
